// File: rtl/fifo_ctrl_param.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_param
//   Parametrised synchronous FIFO (controller + storage) sitting between the
//   key/switch input logic (write side) and the display/consumer logic (read
//   side). Occupancy is tracked by an explicit counter. Full and empty are
//   decoded from that counter, never from pointer comparison.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow flags and their ports.
//
// Parameters
//   DATA_W     data word width
//   ADDR_W     pointer width, DEPTH = 2**ADDR_W
//   AF_THRESH  almost_full  when fifolen >= AF_THRESH
//   AE_THRESH  almost_empty when fifolen <= AE_THRESH
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   clr           synchronous flush, active-high, overrides wr_en/rd_en
//   wr_en/wr_data write request and data
//   rd_en         read request
//   rd_data       registered read data (1-cycle latency), holds between reads
//   rd_valid      one-cycle strobe: rd_data updated this cycle
//   fifofull      fifolen == DEPTH
//   notempty      fifolen != 0
//   almost_full   fifolen >= AF_THRESH
//   almost_empty  fifolen <= AE_THRESH
//   fifolen       occupancy 0..DEPTH
//   overflow      sticky write-while-full flag   (FIFO_ERR_FLAGS_EN only)
//   underflow     sticky read-while-empty flag   (FIFO_ERR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fifo_ctrl_param #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 5,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              fifofull,
  output logic              notempty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifolen
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] PTR_ONE   = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   LEN_AE    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wraddr;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [ADDR_W:0]   r_fifolen;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic w_full;
  logic w_notempty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Status decodes straight from the registered occupancy counter.
  assign w_full     = (r_fifolen == LEN_DEPTH);
  assign w_notempty = (r_fifolen != '0);

  // Accepts are qualified by the status at the edge. When empty, a concurrent
  // write does not bypass to the read side; when full, a concurrent read does
  // not make room for the write in the same cycle. A flush suppresses both.
  assign w_wr_acc = wr_en && !w_full     && !clr;
  assign w_rd_acc = rd_en &&  w_notempty && !clr;

  // NOTE: storage has no reset; contents are only meaningful once written,
  // and leaving it unreset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wraddr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wraddr   <= '0;
      r_rdaddr   <= '0;
      r_fifolen  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clr) begin
      // rd_data intentionally holds across a flush.
      r_wraddr   <= '0;
      r_rdaddr   <= '0;
      r_fifolen  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;

      // Pointers wrap naturally at DEPTH because they are exactly ADDR_W wide.
      if (w_wr_acc) begin
        r_wraddr <= r_wraddr + PTR_ONE;
      end

      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rdaddr];
        r_rdaddr  <= r_rdaddr + PTR_ONE;
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_fifolen <= r_fifolen + LEN_ONE;
        2'b01:   r_fifolen <= r_fifolen - LEN_ONE;
        default: r_fifolen <= r_fifolen;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a flush in the same cycle as an error wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && !w_notempty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign fifofull     = w_full;
  assign notempty     = w_notempty;
  assign almost_full  = (r_fifolen >= LEN_AF);
  assign almost_empty = (r_fifolen <= LEN_AE);
  assign fifolen      = r_fifolen;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl_param
//   Directed self-checking bench for fifo_ctrl_param at default parameters
//   (DATA_W=24, DEPTH=32, AF_THRESH=28, AE_THRESH=2). Expected values are
//   hand-derived from the stimulus. Error-flag checks are compiled in only
//   when FIFO_ERR_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl_param;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              fifofull;
  logic              notempty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fifolen;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  int n_tests;
  int n_fail;

  fifo_ctrl_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_THRESH(28),
    .AE_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifofull    (fifofull),
    .notempty    (notempty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifolen     (fifolen)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of requests from the falling edge, then sample 1 time
  // unit after the rising edge and return inputs to idle.
  task automatic cyc(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr     = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic check_status(input string tag, input int len);
    check({tag, ".len"},  32'(fifolen),      32'(len));
    check({tag, ".full"}, 32'(fifofull),     32'(len == DEPTH));
    check({tag, ".ne"},   32'(notempty),     32'(len != 0));
    check({tag, ".af"},   32'(almost_full),  32'(len >= 28));
    check({tag, ".ae"},   32'(almost_empty), 32'(len <= 2));
  endtask

  task automatic check_read(input string tag, input logic [DATA_W-1:0] exp_data);
    check({tag, ".valid"}, 32'(rd_valid), 32'd1);
    check({tag, ".data"},  32'(rd_data),  32'(exp_data));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    // ---------------- power-on reset ----------------
    #1;
    check_status("por", 0);
    check("por.rd_valid", 32'(rd_valid), 32'd0);
    check("por.rd_data",  32'(rd_data),  32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("por.ovf", 32'(overflow),  32'd0);
    check("por.unf", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- fill 0x000001..0x000020 ----------------
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
      check_status($sformatf("fill%0d", i), i);
    end

    // 33rd write while full is dropped
    cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check_status("overfill", DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
    check("overfill.ovf", 32'(overflow), 32'd1);
`endif

    // ---------------- drain ----------------
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_read($sformatf("drain%0d", i), DATA_W'(i));
      check($sformatf("drain%0d.len", i), 32'(fifolen), 32'(DEPTH - i));
    end
    check_status("drained", 0);

    // idle: strobe drops, data holds
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("idle.valid", 32'(rd_valid), 32'd0);
    check("idle.data",  32'(rd_data),  32'h20);

    // 33rd read while empty is rejected
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("underread.valid", 32'(rd_valid), 32'd0);
    check("underread.data",  32'(rd_data),  32'h20);
    check_status("underread", 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("underread.unf", 32'(underflow), 32'd1);
`endif

    // ---------------- simultaneous read/write at fifolen = 10 ----------------
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, DATA_W'(32'h100 + k), 1'b0, 1'b0);
    end
    check_status("sim.pre", 10);
    for (int j = 0; j < 50; j++) begin
      cyc(1'b1, DATA_W'(32'h200 + j), 1'b1, 1'b0);
      check_read($sformatf("sim%0d", j),
                 (j < 10) ? DATA_W'(32'h100 + j) : DATA_W'(32'h200 + j - 10));
      check($sformatf("sim%0d.len", j), 32'(fifolen), 32'd10);
    end
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_read($sformatf("simdrain%0d", j), DATA_W'(32'h200 + 40 + j));
    end
    check_status("sim.post", 0);

    // ---------------- empty with wr+rd: no bypass ----------------
    cyc(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
    check("emptywr.valid", 32'(rd_valid), 32'd0);
    check("emptywr.data",  32'(rd_data),  32'h231);
    check_status("emptywr", 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_read("emptywr.rd", 24'h5A5A5A);
    check_status("emptywr.rd", 0);

    // ---------------- full with wr+rd: write dropped ----------------
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1'b1, DATA_W'(32'h300 + k), 1'b0, 1'b0);
    end
    check_status("fullwr.pre", DEPTH);
    cyc(1'b1, 24'hDEAD01, 1'b1, 1'b0);
    check_read("fullwr", 24'h000300);
    check_status("fullwr", DEPTH - 1);
    for (int k = 1; k < DEPTH; k++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      check_read($sformatf("fulldrain%0d", k), DATA_W'(32'h300 + k));
    end
    check_status("fulldrain", 0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("fulldrain.extra.valid", 32'(rd_valid), 32'd0);
    check("fulldrain.extra.data",  32'(rd_data),  32'h31F);

    // ---------------- flush with concurrent write ----------------
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, DATA_W'(32'h400 + k), 1'b0, 1'b0);
    end
    check_status("flush.pre", 7);
`ifdef FIFO_ERR_FLAGS_EN
    check("flush.pre.ovf", 32'(overflow), 32'd1);
`endif
    cyc(1'b1, 24'h777777, 1'b0, 1'b1);
    check_status("flush", 0);
    check("flush.valid", 32'(rd_valid), 32'd0);
    check("flush.data",  32'(rd_data),  32'h31F);
`ifdef FIFO_ERR_FLAGS_EN
    check("flush.ovf", 32'(overflow),  32'd0);
    check("flush.unf", 32'(underflow), 32'd0);
`endif
    cyc(1'b1, 24'h888888, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_read("flush.after", 24'h888888);
    check_status("flush.after", 0);

    // clr together with an underflow event leaves the flag clear
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("clrunf.valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("clrunf.unf", 32'(underflow), 32'd0);
`endif

    // ---------------- reset mid-stream at fifolen = 5 ----------------
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, DATA_W'(32'h500 + k), 1'b0, 1'b0);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_read("prerst", 24'h000500);
    check_status("prerst", 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_status("rst.async", 0);
    check("rst.async.valid", 32'(rd_valid), 32'd0);
    check("rst.async.data",  32'(rd_data),  32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_status("rst.hold", 0);
    check("rst.hold.valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 24'h600600, 1'b0, 1'b0);
    check_status("postrst.wr", 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check_read("postrst.rd", 24'h600600);
    check_status("postrst.rd", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
- Parametrised synchronous FIFO: controller and storage array in one block, for the push-button/HEX lab datapath.
- Generalises the fixed 24-bit FIFO to any width and depth.
- Adds almost-full/almost-empty thresholds, a synchronous flush, a registered read-valid strobe and optional sticky error flags.
- Sits between the key/switch input logic (write side) and the display/consumer logic (read side).

Parameters:
DATA_W, 24, data word width in bits
ADDR_W, 5, pointer width; DEPTH = 2**ADDR_W (default 32)
AF_THRESH, 28, almost_full asserts when fifolen >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when fifolen <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  one-cycle strobe: rd_data updated this cycle
fifofull  out  1  fifolen == DEPTH
notempty  out  1  fifolen != 0
almost_full  out  1  fifolen >= AF_THRESH
almost_empty  out  1  fifolen <= AE_THRESH
fifolen  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN
underflow  out  1  sticky; present only with FIFO_ERR_FLAGS_EN

Behaviour:
- Reset (rst low, async): wraddr = rdaddr = 0, fifolen = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0. Storage array is not reset.
- Status outputs:
  - fifofull, notempty, almost_full and almost_empty decode combinationally from the registered fifolen.
  - After reset: fifofull = 0, notempty = 0, almost_full = 0, almost_empty = 1.
- Write accept: wr_en && !fifofull, sampled at the edge. Stores mem[wraddr] = wr_data, then wraddr += 1 mod DEPTH.
- Write while full: rejected. wraddr, fifolen and memory are unchanged.
- Read accept: rd_en && notempty.
  - rd_data <= mem[rdaddr] and rdaddr += 1 mod DEPTH at the same edge.
  - rd_valid = 1 for exactly that following cycle. Latency is 1 clock.
- Read while empty: rejected. rdaddr unchanged, rd_valid = 0, rd_data holds its last value.
- rd_data holds between accepted reads.
- Simultaneous accepted write and read: both pointers advance, fifolen unchanged.
- When full with both requested: read accepted, write rejected; fifolen becomes DEPTH-1.
- When empty with both requested: write accepted, read rejected (no bypass); fifolen becomes 1.
- fifolen: +1 on write-only accept, -1 on read-only accept. Never exceeds DEPTH, never goes below 0.
- Pointers wrap from DEPTH-1 to 0 silently. Full/empty are determined by fifolen, not by pointer comparison.
- clr: at the edge, wraddr = rdaddr = 0, fifolen = 0, rd_valid = 0. rd_data holds. clr overrides wr_en and rd_en in the same cycle; error flags clear too.
- Reset mid-operation: all state returns to reset values immediately. The first edge after rst deasserts behaves as from empty.
- No internal FSM states beyond the pointers and counter; all state is pointers, fifolen, rd_data/rd_valid and the flags.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow and underflow ports exist.
  - overflow sets on wr_en && fifofull; underflow sets on rd_en && !notempty.
  - Both are sticky until rst or clr. clr in the same cycle as an error event leaves the flag clear.
- Undefined: ports and logic are absent. Rejected accesses are silently dropped; all other behaviour is identical.

Test Plan:
- Reset: rst low for 2 clocks mid-stream with fifolen = 5 -> fifolen = 0, wraddr = rdaddr = 0, notempty = 0, almost_empty = 1, rd_valid = 0 while rst is low.
- Fill/overfill (DEPTH = 32): write 0x000001..0x000020 -> fifofull = 1, fifolen = 32, almost_full from fifolen = 28. A 33rd write of 0xABCDEF -> wraddr stable, fifolen 32, overflow = 1 (macro on).
- Drain/underread: read 32 times -> rd_data 0x000001..0x000020, each one cycle after its rd_en, rd_valid pulsed each time. A 33rd read -> rdaddr stable, rd_valid = 0, rd_data = 0x000020, underflow = 1.
- Simultaneous: at fifolen = 10, wr_en and rd_en together for 50 cycles -> fifolen stays 10, both pointers wrap past 31 to 0, data order preserved.
- Boundaries: full with wr+rd -> fifolen 31, oldest word read, new word dropped. Empty with wr+rd -> fifolen 1, rd_valid = 0, later read returns the written word.
- Flush: fifolen = 7 with overflow = 1, assert clr together with wr_en -> next cycle fifolen = 0, notempty = 0, overflow = 0, rd_data unchanged, the write is dropped.
